fetch_prefetch_unit: RTL

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_prefetch_unit_pkg.sv | 34 +++
 rtl/fetch_prefetch_unit_queue.sv | 77 +++++++
 rtl/fetch_prefetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction fetch / prefetch unit: FSM state
// encoding, queue entry layout, reset constants and an alignment helper.
package fetch_prefetch_unit_pkg;

    // Fetch address used after reset when the top is not overridden.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction presented toward IF/ID while the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // IDLE: no request on the bus.
    // REQ : a live request is outstanding; its data will be queued.
    // DROP: a request issued before a redirect is still outstanding; its
    //       data must be thrown away when it finally returns.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// fetch_queue: synchronous FIFO holding prefetched instructions. Flush empties
// it in one edge and wins over push/pop. DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same edge, so push-while-full is legal only
    // together with a pop; the fetch FSM never relies on that, but the guard
    // keeps the occupancy count honest regardless.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // Write the storage array on push.
    // NOTE: the storage is deliberately not reset; cnt alone says which
    // slots hold valid data, and leaving the array resetless keeps it a
    // plain register file / RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Track pointers and occupancy; flush wins over push and pop.
    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: issues sequential word fetches to instruction memory,
// buffers returned words in a small queue and presents the queue head to
// IF/ID. Redirects flush the queue and restart fetching at the new target;
// a request already on the bus when a redirect arrives is allowed to finish
// and its data is dropped.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_addr;
    logic         req_q;

    logic         q_push;
    logic         q_pop;
    logic         q_full;
    logic         q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t q_wdata;
    fetch_entry_t q_rdata;

    logic [CW:0]  count_after;
    logic         room_after;
    logic [31:0]  target_pc;

    // Only a live (non-stale) ack pushes; a redirect in the same cycle
    // discards the word. Pops follow IF/ID acceptance, and a redirect
    // overrides both since it flushes the queue anyway.
    assign q_push    = (state == ST_REQ) && imem_ack && !redirect;
    assign q_pop     = !q_empty && !stall && !redirect;
    assign q_wdata   = '{pc: req_addr, instr: imem_rdata};
    assign target_pc = align_word(redirect_pc);

    // Occupancy after this edge's push/pop decides whether the next request
    // can be issued back-to-back without ever overfilling the queue.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_after = {1'b0, q_count};
        if (q_push) begin
            count_after = count_after + (CW + 1)'(1);
        end
        if (q_pop) begin
            count_after = count_after - (CW + 1)'(1);
        end
        room_after = (count_after < (CW + 1)'(QDEPTH));
    end

    // Fetch FSM: state, next fetch address, bus address and request flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end else if (!q_full) begin
                        state    <= ST_REQ;
                        req_addr <= fetch_pc;
                        req_q    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Returned word is stale; restart from the target.
                            state    <= ST_IDLE;
                            fetch_pc <= target_pc;
                            req_q    <= 1'b0;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            if (room_after) begin
                                req_addr <= fetch_pc + 32'd4;
                            end else begin
                                state <= ST_IDLE;
                                req_q <= 1'b0;
                            end
                        end
                    end else if (redirect) begin
                        // Keep the bus request stable until it is acked.
                        state    <= ST_DROP;
                        fetch_pc <= target_pc;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end
                    if (imem_ack) begin
                        state <= ST_IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_addr;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Empty queue presents a NOP at pc 0 rather than stale storage.
    assign instr_valid = !q_empty;
    assign instr       = q_empty ? NOP_INSTR : q_rdata.instr;
    assign instr_pc    = q_empty ? 32'h0000_0000 : q_rdata.pc;

endmodule
